// File: rtl/somador_sequencial_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM encoding and
// chunk-count helpers derived from the operand width N and chunk width K.
package somador_sequencial_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SOMA   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam int N_PADRAO = 16;
  localparam int K_PADRAO = 4;

  function automatic int num_blocos(input int n, input int k);
    return n / k;
  endfunction

  // Index register is never narrower than one bit, even for a single chunk.
  function automatic int largura_idx(input int n, input int k);
    int nb;
    nb = n / k;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/somador_sequencial_bloco.sv
// Combinational K-bit ripple adder built from one-bit full-adder cells; also
// exposes the carry into its MSB so the caller can derive signed overflow.
module somador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module somador_bloco #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         carry_msb
);

  logic [K:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < K; gi++) begin : g_fa
    somador_completo u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry[gi]),
      .sum  (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  assign cout      = carry[K];
  assign carry_msb = carry[K-1];

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle N-bit adder/subtractor: one K-bit chunk per clock through a single
// shared ripple block, with an iniciar/fim handshake and registered results.
module somador_sequencial
  import somador_sequencial_pkg::*;
#(
  parameter int N = N_PADRAO,
  parameter int K = K_PADRAO
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         iniciar,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ocupado,
  output logic         fim,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int NB = num_blocos(N, K);
  localparam int IW = largura_idx(N, K);

  if ((N % K) != 0 || N <= 0) begin : g_chk_largura
    $fatal(1, "somador_sequencial: N (%0d) must be a positive multiple of K (%0d)", N, K);
  end

  estado_t        estado_reg, estado_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic           carry_reg, carry_next;
  logic [N-1:0]   a_reg, a_next;
  logic [N-1:0]   b_reg, b_next;
  logic [N-1:0]   acc_reg, acc_next;
  logic [N-1:0]   sum_reg, sum_next;
  logic           cout_reg, cout_next;
  logic           ovf_reg, ovf_next;

  logic [K-1:0]   blk_a, blk_b, blk_sum;
  logic           blk_cout, blk_cmsb;
  logic           ultimo_bloco;

  assign blk_a        = a_reg[idx_reg*K +: K];
  assign blk_b        = b_reg[idx_reg*K +: K];
  assign ultimo_bloco = (idx_reg == IW'(NB - 1));

  somador_bloco #(.K(K)) u_bloco (
    .a         (blk_a),
    .b         (blk_b),
    .cin       (carry_reg),
    .sum       (blk_sum),
    .cout      (blk_cout),
    .carry_msb (blk_cmsb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg <= OCIOSO;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      sum_reg    <= sum_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    idx_next    = idx_reg;
    carry_next  = carry_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    sum_next    = sum_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;

    case (estado_reg)
      OCIOSO: begin
        // Subtraction is folded into the operands: a + ~b + ~borrow.
        if (iniciar) begin
          a_next      = a;
          b_next      = sub ? ~b : b;
          carry_next  = sub ? ~cin : cin;
          idx_next    = '0;
          estado_next = SOMA;
        end
      end
      SOMA: begin
        acc_next[idx_reg*K +: K] = blk_sum;
        carry_next               = blk_cout;
        idx_next                 = idx_reg + 1'b1;
        if (ultimo_bloco) begin
          sum_next    = acc_next;
          cout_next   = blk_cout;
          ovf_next    = blk_cmsb ^ blk_cout;
          estado_next = FIM;
        end
      end
      FIM: begin
        estado_next = OCIOSO;
      end
      default: begin
        estado_next = OCIOSO;
      end
    endcase
  end

  assign ocupado  = (estado_reg != OCIOSO);
  assign fim      = (estado_reg == FIM);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed-vector bench for somador_sequencial: a 16-bit/4-bit-chunk instance and
// an 8-bit single-chunk instance, checked against hand-computed results.
module tb_somador_sequencial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        iniciar16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ocupado16, fim16, cout16, ovf16;
  logic [15:0] sum16;

  logic        iniciar8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ocupado8, fim8, cout8, ovf8;
  logic [7:0]  sum8;

  int n_vetores = 0;
  int n_erros   = 0;

  always #5 clock = ~clock;

  somador_sequencial #(.N(16), .K(4)) dut16 (
    .clock    (clock),
    .reset_n  (reset_n),
    .iniciar  (iniciar16),
    .sub      (sub16),
    .a        (a16),
    .b        (b16),
    .cin      (cin16),
    .ocupado  (ocupado16),
    .fim      (fim16),
    .sum      (sum16),
    .cout     (cout16),
    .overflow (ovf16)
  );

  somador_sequencial #(.N(8), .K(8)) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .iniciar  (iniciar8),
    .sub      (sub8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .ocupado  (ocupado8),
    .fim      (fim8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vetores++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %h, expected %h", tag, obs, esp);
    end
  endtask

  // One 16-bit job: acceptance edge t, fim expected only after edge t+4.
  task automatic job16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic vc, input logic [15:0] es,
                       input logic ec, input logic eo);
    @(negedge clock);
    a16 = va; b16 = vb; sub16 = vs; cin16 = vc; iniciar16 = 1'b1;
    @(posedge clock); #1;
    iniciar16 = 1'b0;
    verifica({tag, "_ocupado_t"}, 32'(ocupado16), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
      verifica({tag, "_fim_latencia"}, 32'(fim16), 32'(i == 4));
    end
    verifica({tag, "_sum"}, 32'(sum16), 32'(es));
    verifica({tag, "_cout"}, 32'(cout16), 32'(ec));
    verifica({tag, "_overflow"}, 32'(ovf16), 32'(eo));
    @(posedge clock); #1;
    verifica({tag, "_fim_pulso"}, 32'(fim16), 32'd0);
    verifica({tag, "_ocupado_fim"}, 32'(ocupado16), 32'd0);
    $display("job %s: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d",
             tag, va, vb, vs, vc, sum16, cout16, ovf16);
  endtask

  initial begin
    #2;
    verifica("rst_sum16", 32'(sum16), 32'd0);
    verifica("rst_fim16", 32'(fim16), 32'd0);
    verifica("rst_ocupado16", 32'(ocupado16), 32'd0);
    verifica("rst_cout16", 32'(cout16), 32'd0);
    verifica("rst_ovf16", 32'(ovf16), 32'd0);
    verifica("rst_sum8", 32'(sum8), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    job16("add_basico",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    job16("add_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    job16("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    job16("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    job16("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    job16("sub_cin",     16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // iniciar held high with operands changing every cycle: jobs accepted at
    // edges 0 and 6 only, with a=0x0100 and a=0x0106 respectively.
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      a16 = 16'h0100 + 16'(c); b16 = 16'h0010; sub16 = 1'b0; cin16 = 1'b0;
      iniciar16 = 1'b1;
      @(posedge clock); #1;
      verifica("ocupado_ocupado", 32'(ocupado16), 32'(c % 6 != 5));
      verifica("ocupado_fim", 32'(fim16), 32'(c == 4 || c == 10));
      if (c == 4)  verifica("ocupado_sum1", 32'(sum16), 32'h0110);
      if (c == 10) verifica("ocupado_sum2", 32'(sum16), 32'h0116);
    end
    @(negedge clock);
    iniciar16 = 1'b0;
    $display("job ocupado: two accepted jobs, sum=%h", sum16);

    // Reset two edges after acceptance aborts the job silently.
    @(negedge clock);
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0; iniciar16 = 1'b1;
    @(posedge clock); #1;
    iniciar16 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    verifica("reset_ocupado", 32'(ocupado16), 32'd0);
    verifica("reset_sum", 32'(sum16), 32'd0);
    verifica("reset_fim", 32'(fim16), 32'd0);
    verifica("reset_ovf", 32'(ovf16), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      verifica("reset_sem_fim", 32'(fim16), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    $display("job reset: aborted job, sum=%h", sum16);
    job16("apos_reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Single-chunk variant: fim right after the acceptance edge's successor.
    @(negedge clock);
    a8 = 8'hF0; b8 = 8'h0F; sub8 = 1'b0; cin8 = 1'b1; iniciar8 = 1'b1;
    @(posedge clock); #1;
    iniciar8 = 1'b0;
    verifica("k8_ocupado", 32'(ocupado8), 32'd1);
    verifica("k8_fim_t", 32'(fim8), 32'd0);
    @(posedge clock); #1;
    verifica("k8_fim", 32'(fim8), 32'd1);
    verifica("k8_sum", 32'(sum8), 32'h00);
    verifica("k8_cout", 32'(cout8), 32'd1);
    verifica("k8_ovf", 32'(ovf8), 32'd0);
    @(posedge clock); #1;
    verifica("k8_fim_pulso", 32'(fim8), 32'd0);
    verifica("k8_ocupado_fim", 32'(ocupado8), 32'd0);
    $display("job k8: a=f0 b=0f cin=1 -> sum=%h cout=%0d ovf=%0d", sum8, cout8, ovf8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
